// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - shared funct3 and FSM encodings for the iterative mul/div unit
package muldiv_pkg;

    typedef enum logic [2:0] {
        F3_MUL    = 3'd0,
        F3_MULH   = 3'd1,
        F3_MULHSU = 3'd2,
        F3_MULHU  = 3'd3,
        F3_DIV    = 3'd4,
        F3_DIVU   = 3'd5,
        F3_REM    = 3'd6,
        F3_REMU   = 3'd7
    } funct3_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    localparam logic [5:0] LAST_ITER = 6'd31;

endpackage

// File: rtl/muldiv_signfix.sv
// rtl/muldiv_signfix.sv - conditional two's-complement negate (magnitude and sign restore)
module muldiv_signfix #(
    parameter int W = 32
) (
    input  logic [W-1:0] val,
    input  logic         neg,
    output logic [W-1:0] res
);

    assign res = neg ? -val : val;

endmodule

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - RV32M multiply/divide unit, 32 shift-add / restoring iterations, fixed 34-cycle latency
module muldiv_unit
    import muldiv_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [2:0]  funct3,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        busy,
    output logic        done,
    output logic [31:0] result
);

    state_e      state, state_nxt;
    logic [5:0]  cnt;
    funct3_e     op;
    logic [31:0] opnd;
    logic [31:0] a_orig;
    logic [63:0] acc;
    logic        neg_q, neg_r, b_zero;
    logic [31:0] result_q;

    logic        accept;
    logic        a_signed, b_signed, sa, sb;
    logic [31:0] mag_a, mag_b;

    logic        is_mul, is_rem;
    logic [32:0] mul_sum;
    logic [32:0] rem_sh;
    logic [32:0] div_diff;
    logic [63:0] acc_step;
    logic [63:0] fix_in;
    logic        fix_neg;
    logic [63:0] fix_res;
    logic [31:0] fix_word;

    assign a_signed = (funct3 == F3_MULH) || (funct3 == F3_MULHSU) ||
                      (funct3 == F3_DIV)  || (funct3 == F3_REM);
    assign b_signed = (funct3 == F3_MULH) || (funct3 == F3_DIV) || (funct3 == F3_REM);
    assign sa       = a_signed & A[31];
    assign sb       = b_signed & B[31];

    muldiv_signfix #(.W(32)) u_mag_a (.val(A), .neg(sa), .res(mag_a));
    muldiv_signfix #(.W(32)) u_mag_b (.val(B), .neg(sb), .res(mag_b));

    assign accept = (state == ST_IDLE) && start;
    assign busy   = (state == ST_CALC) || (state == ST_FIX);
    assign done   = (state == ST_DONE);
    assign result = result_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (start) state_nxt = ST_CALC;
            ST_CALC: if (cnt == LAST_ITER) state_nxt = ST_FIX;
            ST_FIX:  state_nxt = ST_DONE;
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign is_mul = ~op[2];
    assign is_rem = op[1];

    // Multiply: multiplier sits in acc[31:0] and shifts out as the product shifts in from the top.
    // Divide: acc holds {partial remainder, dividend-then-quotient}.
    always_comb begin
        mul_sum  = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, opnd} : 33'd0);
        rem_sh   = acc[63:31];
        div_diff = rem_sh - {1'b0, opnd};
        acc_step = {mul_sum, acc[31:1]};
        if (!is_mul) begin
            if (!div_diff[32]) begin
                acc_step = {div_diff[31:0], acc[30:0], 1'b1};
            end else begin
                acc_step = {rem_sh[31:0], acc[30:0], 1'b0};
            end
        end
    end

    always_comb begin
        fix_in  = acc;
        fix_neg = neg_q;
        if (!is_mul) begin
            fix_in  = is_rem ? {32'd0, acc[63:32]} : {32'd0, acc[31:0]};
            fix_neg = is_rem ? neg_r : neg_q;
        end
    end

    muldiv_signfix #(.W(64)) u_fix (.val(fix_in), .neg(fix_neg), .res(fix_res));

    // Divide-by-zero results are forced rather than relying on the signed magnitude path.
    always_comb begin
        fix_word = fix_res[31:0];
        if (is_mul) begin
            fix_word = (op == F3_MUL) ? fix_res[31:0] : fix_res[63:32];
        end else if (b_zero) begin
            fix_word = is_rem ? a_orig : 32'hFFFF_FFFF;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt      <= 6'd0;
            op       <= F3_MUL;
            opnd     <= 32'd0;
            a_orig   <= 32'd0;
            acc      <= 64'd0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            b_zero   <= 1'b0;
            result_q <= 32'd0;
        end else begin
            if (accept) begin
                op     <= funct3_e'(funct3);
                opnd   <= funct3[2] ? mag_b : mag_a;
                acc    <= {32'd0, (funct3[2] ? mag_a : mag_b)};
                a_orig <= A;
                neg_q  <= sa ^ sb;
                neg_r  <= sa;
                b_zero <= (B == 32'd0);
                cnt    <= 6'd0;
            end else if (state == ST_CALC) begin
                acc <= acc_step;
                cnt <= cnt + 6'd1;
            end else if (state == ST_FIX) begin
                result_q <= fix_word;
            end
        end
    end

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 SHALL have port clk, input, 1 bit: single rising-edge clock for all state.
REQ-002 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-003 SHALL have port start, input, 1 bit: request strobe, sampled only in IDLE.
REQ-004 SHALL have port funct3, input, 3 bits: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU (RV32M encoding).
REQ-005 SHALL have port A, input, 32 bits: operand rs1, sampled with start.
REQ-006 SHALL have port B, input, 32 bits: operand rs2, sampled with start.
REQ-007 SHALL have port busy, output, 1 bit: high from the cycle after accept until done.
REQ-008 SHALL have port done, output, 1 bit: one-cycle pulse, result valid.
REQ-009 SHALL have port result, output, 32 bits: result, held until the next accept.

Function
REQ-010 SHALL implement FSM states IDLE -> CALC -> FIX -> DONE -> IDLE.
REQ-011 SHALL accept a request when start=1 in IDLE (cycle 0), latching A, B, funct3.
REQ-012 SHALL ignore start while busy=1 or done=1, with no effect on the in-flight operation.
REQ-013 SHALL iterate exactly 32 CALC cycles (cycles 1..32), one quotient/product bit per cycle, with a 6-bit counter.
REQ-014 SHALL multiply by shift-add on operand magnitudes into a 64-bit accumulator; MUL returns bits[31:0], MULH/MULHSU/MULHU return bits[63:32].
REQ-015 SHALL treat A signed / B signed for MULH, A signed / B unsigned for MULHSU, both unsigned for MULHU.
REQ-016 SHALL divide by restoring division on magnitudes; the quotient truncates toward zero and the remainder takes the sign of A.
REQ-017 SHALL apply two's-complement sign correction in FIX (cycle 33).
REQ-018 SHALL assert done=1 and drive a valid result in DONE (cycle 34); busy SHALL be 0 in that cycle.
REQ-019 SHALL give divide-by-zero the results quotient 0xFFFFFFFF (DIV and DIVU) and remainder = A (REM and REMU).
REQ-020 SHALL give signed overflow (A=0x80000000, B=0xFFFFFFFF) the results DIV 0x80000000 and REM 0x00000000.
REQ-021 SHALL keep latency at 34 cycles for every funct3 and operand value, including REQ-019 and REQ-020 cases.
REQ-022 SHALL allow start=1 in the cycle after DONE (back-to-back) to be accepted.

Reset
REQ-023 SHALL, on rst_n=0, immediately force state IDLE, busy=0, done=0, result=0x00000000, and counter=0.
REQ-024 SHALL abort an in-flight operation on reset with no done pulse; the first start after rst_n rises SHALL be accepted normally.

Structure
REQ-025 SHALL place funct3 encodings and FSM state encodings in a shared muldiv_pkg header used by the unit and the bench.
REQ-026 SHALL contain one combinational sub-module, muldiv_signfix (magnitude/negate and sign-select helper), instantiated for operand preparation and FIX.
REQ-027 SHALL contain no multiplier primitives (no "*" or "/" operators) in the RTL.

Verification
REQ-028 SHALL cover MUL with A=7, B=6 -> done at cycle 34, result=0x0000002A.
REQ-029 SHALL cover the high-word multiplies: MULH 0x80000000*0x80000000 -> 0x40000000; MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE; MULHSU 0xFFFFFFFF*0x00000002 -> 0xFFFFFFFF.
REQ-030 SHALL cover signed division: DIV 0xFFFFFFF9/0x00000002 -> 0xFFFFFFFD; REM of the same operands -> 0xFFFFFFFF.
REQ-031 SHALL cover divide-by-zero and overflow: DIVU 5/0 -> 0xFFFFFFFF; REMU 5/0 -> 0x00000005; DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM of the same operands -> 0x00000000.
REQ-032 SHALL cover start pulsed at cycle 10 of a DIVU 100/7 -> ignored, result 0x0000000E at cycle 34; an immediate back-to-back REMU 100/7 -> 0x00000002 at 34 cycles later.
REQ-033 SHALL cover rst_n low at cycle 15 of a MUL -> busy/done/result 0 asynchronously and no done pulse; a following MUL 3*5 -> 0x0000000F.
